fpu_ss_wb_arbiter: RTL and testbench
====================================

# fpu_ss_wb_arbiter

Writeback arbiter for the FPU subsystem. It sits between three result producers and the single shared result/writeback channel: FPnew output, memory load/store results and CSR-instruction results. The shared channel drives the core result interface and the FP register file write port. The memory result path cannot be back-pressured, so the block buffers memory results in a small FIFO and returns credits upstream. Arbitration is fixed priority with an optional anti-starvation limit.

## Interface
- X_ID_WIDTH, 4, instruction ID width
- FLEN, 32, result data width
- MEM_DEPTH, 2, memory-result FIFO entries (≥1)
- MAX_MEM_STREAK, 4, maximum consecutive memory grants while another source waits (fairness build only, ≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- fpu_valid_i  in  1  FPnew result valid
- fpu_ready_o  out  1  FPnew result accepted
- fpu_id_i / fpu_rd_i / fpu_rd_is_fp_i / fpu_data_i / fpu_status_i  in  X_ID_WIDTH/5/1/FLEN/5  FPnew result fields
- mem_valid_i  in  1  memory result (single-cycle pulse, no ready)
- mem_id_i / mem_rd_i / mem_we_i / mem_data_i  in  X_ID_WIDTH/5/1/FLEN  memory result fields; mem_we_i means FP register write
- csr_valid_i  in  1  CSR result valid
- csr_ready_o  out  1  CSR result accepted
- csr_id_i / csr_data_i  in  X_ID_WIDTH/FLEN  CSR result fields
- mem_credit_o  out  $clog2(MEM_DEPTH+1)  free FIFO entries
- mem_overflow_o  out  1  sticky error: memory result dropped
- wb_valid_o  out  1  output register valid
- wb_ready_i  in  1  downstream accepts
- wb_id_o / wb_rd_o / wb_data_o / wb_status_o  out  X_ID_WIDTH/5/FLEN/5  granted result
- wb_src_o  out  2  source: 0 = FPU, 1 = MEM, 2 = CSR
- wb_fpr_we_o  out  1  FP register file write strobe

## Operation
- Output register:
  - load_en = ~wb_valid_o | wb_ready_i.
  - When load_en is high and any candidate exists, the winner loads into the register and wb_valid_o is set.
  - When load_en is high and no candidate exists, wb_valid_o is cleared.
- Candidates:
  - MEM: the FIFO head when the FIFO is non-empty; otherwise mem_valid_i (bypass).
  - CSR: csr_valid_i.
  - FPU: fpu_valid_i.
- Priority: MEM > CSR > FPU.
- Readies: fpu_ready_o = load_en & ~MEM cand & ~CSR cand (or a forced grant, see Configuration). csr_ready_o likewise. Readies do not depend on the requester's own valid.
- Memory ordering is strict arrival order. The bypass is taken only when the FIFO is empty.
- Non-granted incoming memory result:
  - It is pushed to the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the result is dropped, mem_overflow_o is set and held until reset.
  - Push and pop in the same cycle while full is legal; count is unchanged.
- mem_credit_o = MEM_DEPTH − count (registered count). Upstream issues memory requests only when credit is non-zero.
- wb_status_o is the FPU status for FPU results and 0 otherwise.
- wb_fpr_we_o = wb_valid_o & wb_ready_i & fp_dest, where fp_dest is:
  - fpu_rd_is_fp_i for FPU results;
  - mem_we_i for MEM results;
  - 0 for CSR results.
- Payload holds stable while wb_valid_o & ~wb_ready_i.

## Timing
- Reset values:
  - wb_valid_o = 0; all wb_* fields = 0; wb_fpr_we_o = 0.
  - mem_credit_o = MEM_DEPTH; mem_overflow_o = 0.
  - FIFO empty; streak counter = 0.
  - fpu_ready_o and csr_ready_o go high one combinational delay after reset, when there are no higher-priority candidates.
- Latency:
  - Source handshake in cycle N gives wb_valid_o in cycle N+1.
  - A bypassed memory result also appears at N+1.
  - A FIFO-buffered memory result appears no earlier than 1 cycle after it wins arbitration.
- Throughput: one result per cycle when wb_ready_i is held high.
- Asserting reset mid-operation discards the FIFO contents and the output register immediately (asynchronous reset).

## Configuration
- FPU_SS_WB_FAIRNESS_EN defined:
  - A streak counter (width $clog2(MAX_MEM_STREAK+1)) increments on each MEM grant while CSR or FPU is valid.
  - It clears on any non-MEM grant, and on any cycle with no CSR/FPU request.
  - When counter == MAX_MEM_STREAK and load_en is high, the next grant goes to CSR (else FPU). A pending memory result is then pushed to the FIFO.
- FPU_SS_WB_FAIRNESS_EN undefined: strict MEM > CSR > FPU priority; no counter logic.

## Test plan
- Reset, then FPU result (id 3, rd 5, fp) with wb_ready_i = 1 → wb_valid_o in the next cycle with wb_src_o = 0, wb_rd_o = 5, wb_fpr_we_o = 1; mem_credit_o = 2.
- Same-cycle FPU, CSR and MEM (id 1, rd 7, we = 1) valid → MEM granted via bypass, then CSR, then FPU, in cycles N+1, N+2, N+3; fpu_ready_o is low for 2 cycles.
- wb_ready_i = 0 with 3 memory pulses, MEM_DEPTH = 2 → first result held in the output register, next two fill the FIFO, mem_credit_o reaches 0. A fourth pulse sets mem_overflow_o = 1 and is never output.
- Full FIFO with wb_ready_i = 1 and a new memory pulse arriving as the head is granted → no overflow, credit stays 0, results emerge in arrival order.
- Fairness build, MAX_MEM_STREAK = 4, memory pulse every cycle with FPU valid → FPU granted after exactly 4 consecutive MEM grants. Non-fairness build: FPU not granted until memory traffic stops.

Source files
------------

// File: rtl/fpu_ss_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_ss_wb_arbiter
//
// Writeback arbiter for the FPU subsystem. Three result producers (memory,
// CSR, FPnew) share one registered writeback channel that feeds the core
// result interface and the FP register file write port.
//
// Memory results arrive as single-cycle pulses with no back-pressure. They
// are either bypassed straight into the output register (FIFO empty and
// memory wins) or buffered in a small FIFO. Free FIFO entries are reported
// upstream as credits.
//
// Priority is MEM > CSR > FPU. When the FPU_SS_WB_FAIRNESS_EN macro is
// defined, a streak counter limits consecutive memory grants while CSR/FPU
// wait. Once the limit is reached one grant is forced to CSR (else FPU).
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   fpu_valid_i / fpu_ready_o   FPnew result handshake
//   fpu_id_i, fpu_rd_i, fpu_rd_is_fp_i, fpu_data_i, fpu_status_i
//   mem_valid_i                 memory result pulse (no ready)
//   mem_id_i, mem_rd_i, mem_we_i, mem_data_i
//   csr_valid_i / csr_ready_o   CSR result handshake
//   csr_id_i, csr_data_i
//   mem_credit_o                free memory FIFO entries
//   mem_overflow_o              sticky: a memory result was dropped
//   wb_valid_o / wb_ready_i     writeback output register handshake
//   wb_id_o, wb_rd_o, wb_data_o, wb_status_o, wb_src_o (0 FPU, 1 MEM, 2 CSR)
//   wb_fpr_we_o                 FP register file write strobe
// -----------------------------------------------------------------------------
module fpu_ss_wb_arbiter #(
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned FLEN           = 32,
  parameter int unsigned MEM_DEPTH      = 2,
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  // FPnew result
  input  logic                           fpu_valid_i,
  output logic                           fpu_ready_o,
  input  logic [X_ID_WIDTH-1:0]          fpu_id_i,
  input  logic [4:0]                     fpu_rd_i,
  input  logic                           fpu_rd_is_fp_i,
  input  logic [FLEN-1:0]                fpu_data_i,
  input  logic [4:0]                     fpu_status_i,
  // Memory result
  input  logic                           mem_valid_i,
  input  logic [X_ID_WIDTH-1:0]          mem_id_i,
  input  logic [4:0]                     mem_rd_i,
  input  logic                           mem_we_i,
  input  logic [FLEN-1:0]                mem_data_i,
  // CSR result
  input  logic                           csr_valid_i,
  output logic                           csr_ready_o,
  input  logic [X_ID_WIDTH-1:0]          csr_id_i,
  input  logic [FLEN-1:0]                csr_data_i,
  // Memory flow control
  output logic [$clog2(MEM_DEPTH+1)-1:0] mem_credit_o,
  output logic                           mem_overflow_o,
  // Writeback channel
  output logic                           wb_valid_o,
  input  logic                           wb_ready_i,
  output logic [X_ID_WIDTH-1:0]          wb_id_o,
  output logic [4:0]                     wb_rd_o,
  output logic [FLEN-1:0]                wb_data_o,
  output logic [4:0]                     wb_status_o,
  output logic [1:0]                     wb_src_o,
  output logic                           wb_fpr_we_o
);

  localparam int unsigned CNT_W = $clog2(MEM_DEPTH + 1);
  localparam int unsigned PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(MEM_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    SRC_FPU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_CSR = 2'd2
  } src_e;

  // Circular pointer advance that also handles non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [X_ID_WIDTH-1:0] r_fifo_id   [MEM_DEPTH];
  logic [4:0]            r_fifo_rd   [MEM_DEPTH];
  logic                  r_fifo_we   [MEM_DEPTH];
  logic [FLEN-1:0]       r_fifo_data [MEM_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_credit;
  logic                  r_overflow;

  logic                  r_wb_valid;
  logic [X_ID_WIDTH-1:0] r_wb_id;
  logic [4:0]            r_wb_rd;
  logic [FLEN-1:0]       r_wb_data;
  logic [4:0]            r_wb_status;
  src_e                  r_wb_src;
  logic                  r_wb_fp_dest;

  // ---------------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------------
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_load_en;
  logic                  w_mem_cand;
  logic                  w_force;
  logic                  w_grant_mem;
  logic                  w_grant_csr;
  logic                  w_grant_fpu;
  logic                  w_any_grant;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_push_ok;
  logic                  w_drop;

  logic [X_ID_WIDTH-1:0] w_mem_id;
  logic [4:0]            w_mem_rd;
  logic                  w_mem_we;
  logic [FLEN-1:0]       w_mem_data;

  src_e                  w_nxt_src;
  logic [X_ID_WIDTH-1:0] w_nxt_id;
  logic [4:0]            w_nxt_rd;
  logic [FLEN-1:0]       w_nxt_data;
  logic [4:0]            w_nxt_status;
  logic                  w_nxt_fp_dest;

  // The credit register doubles as the occupancy count (credit = depth - count).
  assign w_fifo_empty = (r_credit == DEPTH_C);
  assign w_fifo_full  = (r_credit == {CNT_W{1'b0}});
  assign w_load_en    = ~r_wb_valid | wb_ready_i;
  assign w_mem_cand   = ~w_fifo_empty | mem_valid_i;

`ifdef FPU_SS_WB_FAIRNESS_EN
  localparam int unsigned STREAK_W = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

  logic [STREAK_W-1:0] r_streak;

  // Memory is preempted for exactly one grant once the streak limit is hit.
  assign w_force = (r_streak == STREAK_MAX);

  // Consecutive memory grants observed while CSR or FPU is waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_streak <= {STREAK_W{1'b0}};
    end else if (!(csr_valid_i || fpu_valid_i)) begin
      r_streak <= {STREAK_W{1'b0}};
    end else if (w_grant_csr || w_grant_fpu) begin
      r_streak <= {STREAK_W{1'b0}};
    end else if (w_grant_mem && (r_streak != STREAK_MAX)) begin
      r_streak <= r_streak + STREAK_W'(1);
    end else begin
      r_streak <= r_streak;
    end
  end
`else
  // Strict priority: memory is never preempted. A streak limit of zero would
  // be degenerate and is outside the legal range, so this is constant low.
  assign w_force = (MAX_MEM_STREAK == 32'd0);
`endif

  // Memory candidate: FIFO head keeps arrival order; bypass only when empty.
  always_comb begin
    w_mem_id   = mem_id_i;
    w_mem_rd   = mem_rd_i;
    w_mem_we   = mem_we_i;
    w_mem_data = mem_data_i;
    if (!w_fifo_empty) begin
      w_mem_id   = r_fifo_id[r_rd_ptr];
      w_mem_rd   = r_fifo_rd[r_rd_ptr];
      w_mem_we   = r_fifo_we[r_rd_ptr];
      w_mem_data = r_fifo_data[r_rd_ptr];
    end else begin
      w_mem_id   = mem_id_i;
      w_mem_rd   = mem_rd_i;
      w_mem_we   = mem_we_i;
      w_mem_data = mem_data_i;
    end
  end

  // Fixed-priority grant, with memory skipped while the fairness force is up.
  always_comb begin
    w_grant_mem = 1'b0;
    w_grant_csr = 1'b0;
    w_grant_fpu = 1'b0;
    if (w_load_en) begin
      if (w_mem_cand && !w_force) begin
        w_grant_mem = 1'b1;
      end else if (csr_valid_i) begin
        w_grant_csr = 1'b1;
      end else if (fpu_valid_i) begin
        w_grant_fpu = 1'b1;
      end else begin
        w_grant_mem = 1'b0;
      end
    end else begin
      w_grant_mem = 1'b0;
    end
  end

  assign w_any_grant = w_grant_mem | w_grant_csr | w_grant_fpu;

  // Readies are computed from higher-priority requesters only, never from the
  // requester's own valid, so upstream can present data in the same cycle.
  assign csr_ready_o = w_load_en & (~w_mem_cand | w_force);
  assign fpu_ready_o = w_load_en & ~csr_valid_i & (~w_mem_cand | w_force);

  // FIFO control: any incoming pulse not taken by the bypass is buffered.
  assign w_pop     = w_grant_mem & ~w_fifo_empty;
  assign w_bypass  = w_grant_mem & w_fifo_empty;
  assign w_push    = mem_valid_i & ~w_bypass;
  assign w_push_ok = w_push & (~w_fifo_full | w_pop);
  assign w_drop    = w_push & w_fifo_full & ~w_pop;

  // Payload of the winning source.
  always_comb begin
    w_nxt_src     = SRC_FPU;
    w_nxt_id      = fpu_id_i;
    w_nxt_rd      = fpu_rd_i;
    w_nxt_data    = fpu_data_i;
    w_nxt_status  = fpu_status_i;
    w_nxt_fp_dest = fpu_rd_is_fp_i;
    if (w_grant_mem) begin
      w_nxt_src     = SRC_MEM;
      w_nxt_id      = w_mem_id;
      w_nxt_rd      = w_mem_rd;
      w_nxt_data    = w_mem_data;
      w_nxt_status  = 5'd0;
      w_nxt_fp_dest = w_mem_we;
    end else if (w_grant_csr) begin
      w_nxt_src     = SRC_CSR;
      w_nxt_id      = csr_id_i;
      w_nxt_rd      = 5'd0;
      w_nxt_data    = csr_data_i;
      w_nxt_status  = 5'd0;
      w_nxt_fp_dest = 1'b0;
    end else begin
      w_nxt_src     = SRC_FPU;
      w_nxt_id      = fpu_id_i;
      w_nxt_rd      = fpu_rd_i;
      w_nxt_data    = fpu_data_i;
      w_nxt_status  = fpu_status_i;
      w_nxt_fp_dest = fpu_rd_is_fp_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Memory FIFO storage, pointers, credit counter and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_fifo_id[i]   <= {X_ID_WIDTH{1'b0}};
        r_fifo_rd[i]   <= 5'd0;
        r_fifo_we[i]   <= 1'b0;
        r_fifo_data[i] <= {FLEN{1'b0}};
      end
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_credit   <= DEPTH_C;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_fifo_id[r_wr_ptr]   <= mem_id_i;
        r_fifo_rd[r_wr_ptr]   <= mem_rd_i;
        r_fifo_we[r_wr_ptr]   <= mem_we_i;
        r_fifo_data[r_wr_ptr] <= mem_data_i;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (w_push_ok && !w_pop) begin
        r_credit <= r_credit - CNT_W'(1);
      end else if (w_pop && !w_push_ok) begin
        r_credit <= r_credit + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Writeback output register: loads the winner, holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid   <= 1'b0;
      r_wb_id      <= {X_ID_WIDTH{1'b0}};
      r_wb_rd      <= 5'd0;
      r_wb_data    <= {FLEN{1'b0}};
      r_wb_status  <= 5'd0;
      r_wb_src     <= SRC_FPU;
      r_wb_fp_dest <= 1'b0;
    end else if (w_load_en) begin
      if (w_any_grant) begin
        r_wb_valid   <= 1'b1;
        r_wb_id      <= w_nxt_id;
        r_wb_rd      <= w_nxt_rd;
        r_wb_data    <= w_nxt_data;
        r_wb_status  <= w_nxt_status;
        r_wb_src     <= w_nxt_src;
        r_wb_fp_dest <= w_nxt_fp_dest;
      end else begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign mem_credit_o   = r_credit;
  assign mem_overflow_o = r_overflow;
  assign wb_valid_o     = r_wb_valid;
  assign wb_id_o        = r_wb_id;
  assign wb_rd_o        = r_wb_rd;
  assign wb_data_o      = r_wb_data;
  assign wb_status_o    = r_wb_status;
  assign wb_src_o       = r_wb_src;
  // Strobe only on the accepting handshake so a stalled result writes once.
  assign wb_fpr_we_o    = r_wb_valid & wb_ready_i & r_wb_fp_dest;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for fpu_ss_wb_arbiter with default parameters
// (X_ID_WIDTH 4, FLEN 32, MEM_DEPTH 2, MAX_MEM_STREAK 4). Inputs are driven
// 1 ns after the rising edge and outputs are checked 1-2 ns after it.
// -----------------------------------------------------------------------------
module tb_fpu_ss_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fpu_valid_i, fpu_ready_o;
  logic [3:0]  fpu_id_i;
  logic [4:0]  fpu_rd_i;
  logic        fpu_rd_is_fp_i;
  logic [31:0] fpu_data_i;
  logic [4:0]  fpu_status_i;
  logic        mem_valid_i;
  logic [3:0]  mem_id_i;
  logic [4:0]  mem_rd_i;
  logic        mem_we_i;
  logic [31:0] mem_data_i;
  logic        csr_valid_i, csr_ready_o;
  logic [3:0]  csr_id_i;
  logic [31:0] csr_data_i;
  logic [1:0]  mem_credit_o;
  logic        mem_overflow_o;
  logic        wb_valid_o, wb_ready_i;
  logic [3:0]  wb_id_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_status_o;
  logic [1:0]  wb_src_o;
  logic        wb_fpr_we_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  fpu_ss_wb_arbiter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fpu_valid_i    (fpu_valid_i),
    .fpu_ready_o    (fpu_ready_o),
    .fpu_id_i       (fpu_id_i),
    .fpu_rd_i       (fpu_rd_i),
    .fpu_rd_is_fp_i (fpu_rd_is_fp_i),
    .fpu_data_i     (fpu_data_i),
    .fpu_status_i   (fpu_status_i),
    .mem_valid_i    (mem_valid_i),
    .mem_id_i       (mem_id_i),
    .mem_rd_i       (mem_rd_i),
    .mem_we_i       (mem_we_i),
    .mem_data_i     (mem_data_i),
    .csr_valid_i    (csr_valid_i),
    .csr_ready_o    (csr_ready_o),
    .csr_id_i       (csr_id_i),
    .csr_data_i     (csr_data_i),
    .mem_credit_o   (mem_credit_o),
    .mem_overflow_o (mem_overflow_o),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_id_o        (wb_id_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o),
    .wb_status_o    (wb_status_o),
    .wb_src_o       (wb_src_o),
    .wb_fpr_we_o    (wb_fpr_we_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_set(input logic [3:0] id, input logic [4:0] rd, input logic we,
                         input logic [31:0] data);
    mem_valid_i = 1'b1;
    mem_id_i    = id;
    mem_rd_i    = rd;
    mem_we_i    = we;
    mem_data_i  = data;
  endtask

  logic [1:0] exp_src [9];
  logic [3:0] exp_id  [9];
  logic       hs;

  initial begin
`ifdef FPU_SS_WB_FAIRNESS_EN
    exp_src = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    exp_id  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd4, 4'd5, 4'd6, 4'd7};
`else
    exp_src = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    exp_id  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
`endif
    rst_ni = 1'b0;
    fpu_valid_i = 1'b0; fpu_id_i = 4'd0; fpu_rd_i = 5'd0; fpu_rd_is_fp_i = 1'b0;
    fpu_data_i = 32'd0; fpu_status_i = 5'd0;
    mem_valid_i = 1'b0; mem_id_i = 4'd0; mem_rd_i = 5'd0; mem_we_i = 1'b0; mem_data_i = 32'd0;
    csr_valid_i = 1'b0; csr_id_i = 4'd0; csr_data_i = 32'd0;
    wb_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_id", 64'(wb_id_o), 64'd0);
    chk("rst_data", 64'(wb_data_o), 64'd0);
    chk("rst_src", 64'(wb_src_o), 64'd0);
    chk("rst_fpr_we", 64'(wb_fpr_we_o), 64'd0);
    chk("rst_credit", 64'(mem_credit_o), 64'd2);
    chk("rst_overflow", 64'(mem_overflow_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    chk("rst_fpu_ready", 64'(fpu_ready_o), 64'd1);
    chk("rst_csr_ready", 64'(csr_ready_o), 64'd1);

    // Single FPU result, written to an FP register
    tick();
    fpu_valid_i = 1'b1; fpu_id_i = 4'd3; fpu_rd_i = 5'd5; fpu_rd_is_fp_i = 1'b1;
    fpu_data_i = 32'h3f80_0000; fpu_status_i = 5'h01;
    #1;
    chk("t1_fpu_ready", 64'(fpu_ready_o), 64'd1);
    tick();
    fpu_valid_i = 1'b0;
    chk("t1_valid", 64'(wb_valid_o), 64'd1);
    chk("t1_src", 64'(wb_src_o), 64'd0);
    chk("t1_id", 64'(wb_id_o), 64'd3);
    chk("t1_rd", 64'(wb_rd_o), 64'd5);
    chk("t1_data", 64'(wb_data_o), 64'h3f80_0000);
    chk("t1_status", 64'(wb_status_o), 64'h01);
    chk("t1_fpr_we", 64'(wb_fpr_we_o), 64'd1);
    chk("t1_credit", 64'(mem_credit_o), 64'd2);
    tick();
    chk("t1_idle", 64'(wb_valid_o), 64'd0);

    // Same-cycle MEM, CSR and FPU: MEM (bypass), then CSR, then FPU
    fpu_valid_i = 1'b1; fpu_id_i = 4'd2; fpu_rd_i = 5'd4; fpu_rd_is_fp_i = 1'b0;
    fpu_data_i = 32'h4000_0000; fpu_status_i = 5'h04;
    csr_valid_i = 1'b1; csr_id_i = 4'd5; csr_data_i = 32'h0000_aaaa;
    mem_set(4'd1, 5'd7, 1'b1, 32'h0000_1234);
    #1;
    chk("t2_fpu_ready_c0", 64'(fpu_ready_o), 64'd0);
    chk("t2_csr_ready_c0", 64'(csr_ready_o), 64'd0);
    tick();
    mem_valid_i = 1'b0;
    chk("t2_mem_src", 64'(wb_src_o), 64'd1);
    chk("t2_mem_id", 64'(wb_id_o), 64'd1);
    chk("t2_mem_rd", 64'(wb_rd_o), 64'd7);
    chk("t2_mem_data", 64'(wb_data_o), 64'h1234);
    chk("t2_mem_status", 64'(wb_status_o), 64'd0);
    chk("t2_mem_fpr_we", 64'(wb_fpr_we_o), 64'd1);
    #1;
    chk("t2_fpu_ready_c1", 64'(fpu_ready_o), 64'd0);
    chk("t2_csr_ready_c1", 64'(csr_ready_o), 64'd1);
    tick();
    csr_valid_i = 1'b0;
    chk("t2_csr_src", 64'(wb_src_o), 64'd2);
    chk("t2_csr_id", 64'(wb_id_o), 64'd5);
    chk("t2_csr_data", 64'(wb_data_o), 64'haaaa);
    chk("t2_csr_fpr_we", 64'(wb_fpr_we_o), 64'd0);
    #1;
    chk("t2_fpu_ready_c2", 64'(fpu_ready_o), 64'd1);
    tick();
    fpu_valid_i = 1'b0;
    chk("t2_fpu_src", 64'(wb_src_o), 64'd0);
    chk("t2_fpu_id", 64'(wb_id_o), 64'd2);
    chk("t2_fpu_status", 64'(wb_status_o), 64'h04);
    chk("t2_fpu_fpr_we", 64'(wb_fpr_we_o), 64'd0);
    tick();
    chk("t2_idle", 64'(wb_valid_o), 64'd0);

    // Stalled output: fill FIFO, then overflow
    wb_ready_i = 1'b0;
    mem_set(4'd8, 5'd1, 1'b1, 32'h0000_000a);
    tick();
    chk("t3_a_valid", 64'(wb_valid_o), 64'd1);
    chk("t3_a_id", 64'(wb_id_o), 64'd8);
    chk("t3_a_fpr_we_stalled", 64'(wb_fpr_we_o), 64'd0);
    chk("t3_a_credit", 64'(mem_credit_o), 64'd2);
    mem_set(4'd9, 5'd2, 1'b0, 32'h0000_000b);
    #1;
    chk("t3_fpu_ready_stalled", 64'(fpu_ready_o), 64'd0);
    tick();
    chk("t3_b_credit", 64'(mem_credit_o), 64'd1);
    chk("t3_b_hold_id", 64'(wb_id_o), 64'd8);
    mem_set(4'd10, 5'd3, 1'b0, 32'h0000_000c);
    tick();
    chk("t3_c_credit", 64'(mem_credit_o), 64'd0);
    chk("t3_c_overflow", 64'(mem_overflow_o), 64'd0);
    mem_set(4'd11, 5'd4, 1'b0, 32'h0000_000d);
    tick();
    mem_valid_i = 1'b0;
    chk("t3_d_overflow", 64'(mem_overflow_o), 64'd1);
    chk("t3_d_credit", 64'(mem_credit_o), 64'd0);
    chk("t3_d_hold_id", 64'(wb_id_o), 64'd8);
    wb_ready_i = 1'b1;
    #1;
    chk("t3_a_fpr_we", 64'(wb_fpr_we_o), 64'd1);
    tick();
    chk("t3_drain_b", 64'(wb_id_o), 64'd9);
    chk("t3_drain_b_credit", 64'(mem_credit_o), 64'd1);
    tick();
    chk("t3_drain_c", 64'(wb_id_o), 64'd10);
    chk("t3_drain_c_credit", 64'(mem_credit_o), 64'd2);
    tick();
    chk("t3_d_never_out", 64'(wb_valid_o), 64'd0);
    chk("t3_overflow_sticky", 64'(mem_overflow_o), 64'd1);

    // Asynchronous reset mid-operation discards FIFO and output register
    wb_ready_i = 1'b0;
    mem_set(4'd1, 5'd1, 1'b0, 32'h1);
    tick();
    mem_set(4'd2, 5'd2, 1'b0, 32'h2);
    tick();
    mem_valid_i = 1'b0;
    chk("t4_pre_credit", 64'(mem_credit_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t4_rst_valid", 64'(wb_valid_o), 64'd0);
    chk("t4_rst_credit", 64'(mem_credit_o), 64'd2);
    chk("t4_rst_overflow", 64'(mem_overflow_o), 64'd0);
    chk("t4_rst_id", 64'(wb_id_o), 64'd0);
    #1;
    rst_ni = 1'b1;
    tick();

    // Full FIFO, new pulse arrives as the head is granted
    mem_set(4'd4, 5'd4, 1'b1, 32'h44);
    tick();
    mem_set(4'd5, 5'd5, 1'b0, 32'h55);
    tick();
    mem_set(4'd6, 5'd6, 1'b0, 32'h66);
    tick();
    chk("t5_full_credit", 64'(mem_credit_o), 64'd0);
    chk("t5_head_id", 64'(wb_id_o), 64'd4);
    wb_ready_i = 1'b1;
    mem_set(4'd7, 5'd7, 1'b0, 32'h77);
    tick();
    mem_valid_i = 1'b0;
    chk("t5_no_overflow", 64'(mem_overflow_o), 64'd0);
    chk("t5_credit_kept", 64'(mem_credit_o), 64'd0);
    chk("t5_order_5", 64'(wb_id_o), 64'd5);
    tick();
    chk("t5_order_6", 64'(wb_id_o), 64'd6);
    chk("t5_credit_1", 64'(mem_credit_o), 64'd1);
    tick();
    chk("t5_order_7", 64'(wb_id_o), 64'd7);
    chk("t5_order_7_data", 64'(wb_data_o), 64'h77);
    chk("t5_credit_2", 64'(mem_credit_o), 64'd2);
    tick();
    chk("t5_idle", 64'(wb_valid_o), 64'd0);

    // Continuous memory traffic with FPU waiting
    fpu_valid_i = 1'b1; fpu_id_i = 4'd9; fpu_rd_i = 5'd3; fpu_rd_is_fp_i = 1'b1;
    fpu_data_i = 32'h9; fpu_status_i = 5'h02;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        mem_set(4'(k), 5'(k), 1'b0, 32'(k));
      end else begin
        mem_valid_i = 1'b0;
      end
      #1;
      hs = fpu_ready_o & fpu_valid_i;
      tick();
      if (hs) begin
        fpu_valid_i = 1'b0;
      end
      chk($sformatf("t6_src_%0d", k), 64'(wb_src_o), 64'(exp_src[k]));
      chk($sformatf("t6_id_%0d", k), 64'(wb_id_o), 64'(exp_id[k]));
    end
    mem_valid_i = 1'b0;
    fpu_valid_i = 1'b0;
    tick();
    chk("t6_idle", 64'(wb_valid_o), 64'd0);
    chk("t6_credit", 64'(mem_credit_o), 64'd2);
    chk("t6_overflow", 64'(mem_overflow_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
